// File: rtl/uart_flash_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_flash_bridge_if
//  Description : Signal bundle between the UART byte side, the flash
//                controller handshake and the status outputs of
//                uart_flash_bridge.
//                master : the bridge itself
//                slave  : the surrounding UART / flash / status logic
//  Signals     : rx_data/rx_valid    received byte and its strobe
//                tx_data/tx_start    byte to send and its strobe
//                tx_busy             UART transmitter busy
//                fl_addr/fl_wdata    flash address and write data
//                fl_rdata/fl_done    flash read data and completion strobe
//                fl_rw/fl_start      direction (1=read) and start strobe
//                busy/err_cnt        bridge busy flag, saturating error count
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_flash_bridge_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic [ADDR_W-1:0] fl_addr;
    logic [DATA_W-1:0] fl_wdata;
    logic [DATA_W-1:0] fl_rdata;
    logic              fl_rw;
    logic              fl_start;
    logic              fl_done;
    logic              busy;
    logic [7:0]        err_cnt;

    modport master (
        input  rx_data, rx_valid, tx_busy, fl_rdata, fl_done,
        output tx_data, tx_start, fl_addr, fl_wdata, fl_rw, fl_start, busy, err_cnt
    );

    modport slave (
        output rx_data, rx_valid, tx_busy, fl_rdata, fl_done,
        input  tx_data, tx_start, fl_addr, fl_wdata, fl_rw, fl_start, busy, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/uart_flash_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : uart_flash_bridge
//  Description : Command bridge from UART bytes to a flash controller.
//                'W' + address + data -> flash write, replies ACK (0x06).
//                'R' + address        -> flash read, replies the data bytes.
//                Errors (bad opcode, inter-byte timeout, flash timeout,
//                bytes received while busy, bad checksum) reply NAK (0x15)
//                where applicable and bump a saturating error counter.
//                Multi-byte fields are sent MSB byte first.
//  Option      : `define UART_FLASH_BRIDGE_CHECKSUM_EN adds a trailing XOR
//                checksum byte to every command (state S_CSUM).
//  Ports       : CLK_50MHZ  system clock
//                RST_N      asynchronous active-low reset
//                bus        uart_flash_bridge_if.master (UART, flash, status)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_flash_bridge #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int RX_TIMEOUT = 5_000_000,
    parameter int FL_TIMEOUT = 50_000
) (
    input  logic                CLK_50MHZ,
    input  logic                RST_N,
    uart_flash_bridge_if.master bus
);

    localparam int          c_ADDR_BYTES = ADDR_W / 8;
    localparam int          c_DATA_BYTES = DATA_W / 8;
    localparam logic [7:0]  c_OP_WR      = 8'h57;
    localparam logic [7:0]  c_OP_RD      = 8'h52;
    localparam logic [7:0]  c_ACK        = 8'h06;
    localparam logic [7:0]  c_NAK        = 8'h15;
    localparam logic [31:0] c_RX_LAST    = 32'(RX_TIMEOUT - 1);
    localparam logic [31:0] c_FL_LAST    = 32'(FL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_DATA    = 3'd2,
        S_FL_REQ  = 3'd3,
        S_FL_WAIT = 3'd4,
        S_RESP    = 3'd5,
        S_TX_WAIT = 3'd6
`ifdef UART_FLASH_BRIDGE_CHECKSUM_EN
        , S_CSUM  = 3'd7
`endif
    } state_t;

    // State entered after the last address/data byte of a command
`ifdef UART_FLASH_BRIDGE_CHECKSUM_EN
    localparam state_t c_CMD_END = S_CSUM;
`else
    localparam state_t c_CMD_END = S_FL_REQ;
`endif

    state_t            r_state;
    state_t            w_next;
    logic              r_op_rd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_resp;       // outgoing bytes, current one in the top byte
    logic [1:0]        r_byte_cnt;
    logic [1:0]        r_tx_left;
    logic              r_tx_skip;    // cycle after TX_START: tx_busy not yet valid
    logic              r_nak;
    logic [31:0]       r_timer;
    logic [7:0]        r_err_cnt;
`ifdef UART_FLASH_BRIDGE_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic w_rx_phase;
    logic w_locked;
    logic w_last_addr;
    logic w_last_data;
    logic w_rx_to;
    logic w_fl_to;
    logic w_tx_fire;
    logic w_nak;
    logic w_err;

`ifdef UART_FLASH_BRIDGE_CHECKSUM_EN
    assign w_rx_phase = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_CSUM);
`else
    assign w_rx_phase = (r_state == S_ADDR) || (r_state == S_DATA);
`endif
    assign w_locked    = (r_state == S_FL_REQ) || (r_state == S_FL_WAIT) ||
                         (r_state == S_RESP)   || (r_state == S_TX_WAIT);
    assign w_last_addr = (r_byte_cnt == 2'(c_ADDR_BYTES - 1));
    assign w_last_data = (r_byte_cnt == 2'(c_DATA_BYTES - 1));
    assign w_rx_to     = w_rx_phase && (r_timer == c_RX_LAST);
    assign w_fl_to     = (r_state == S_FL_WAIT) && (r_timer == c_FL_LAST);
    assign w_tx_fire   = (r_state == S_TX_WAIT) && !r_tx_skip && !bus.tx_busy;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        w_nak  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    if ((bus.rx_data == c_OP_WR) || (bus.rx_data == c_OP_RD)) begin
                        w_next = S_ADDR;
                    end else begin
                        w_next = S_RESP;
                        w_nak  = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (bus.rx_valid) begin
                    if (w_last_addr) w_next = r_op_rd ? c_CMD_END : S_DATA;
                end else if (w_rx_to) begin
                    w_next = S_RESP;
                    w_nak  = 1'b1;
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    if (w_last_data) w_next = c_CMD_END;
                end else if (w_rx_to) begin
                    w_next = S_RESP;
                    w_nak  = 1'b1;
                end
            end
`ifdef UART_FLASH_BRIDGE_CHECKSUM_EN
            S_CSUM: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == r_csum) begin
                        w_next = S_FL_REQ;
                    end else begin
                        w_next = S_RESP;
                        w_nak  = 1'b1;
                    end
                end else if (w_rx_to) begin
                    w_next = S_RESP;
                    w_nak  = 1'b1;
                end
            end
`endif
            S_FL_REQ:  w_next = S_FL_WAIT;
            S_FL_WAIT: begin
                if (bus.fl_done) begin
                    w_next = S_RESP;
                end else if (w_fl_to) begin
                    w_next = S_RESP;
                    w_nak  = 1'b1;
                end
            end
            S_RESP:    w_next = S_TX_WAIT;
            S_TX_WAIT: begin
                if (w_tx_fire && (r_tx_left == 2'd1)) w_next = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
        // Simultaneous error sources collapse into a single increment
        w_err = w_nak || (bus.rx_valid && w_locked);
    end

    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            r_op_rd    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_resp     <= '0;
            r_byte_cnt <= '0;
            r_tx_left  <= '0;
            r_tx_skip  <= 1'b0;
            r_nak      <= 1'b0;
            r_timer    <= '0;
            r_err_cnt  <= '0;
`ifdef UART_FLASH_BRIDGE_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            // One timer serves both the inter-byte and flash timeouts;
            // it restarts on every state change and on each received byte.
            if ((w_next != r_state) || (w_rx_phase && bus.rx_valid))
                r_timer <= '0;
            else if (w_rx_phase || (r_state == S_FL_WAIT))
                r_timer <= r_timer + 32'd1;

            if (w_next != r_state)
                r_byte_cnt <= '0;
            else if (w_rx_phase && bus.rx_valid)
                r_byte_cnt <= r_byte_cnt + 2'd1;

            if ((r_state == S_IDLE) && bus.rx_valid)
                r_op_rd <= (bus.rx_data == c_OP_RD);
            if ((r_state == S_ADDR) && bus.rx_valid)
                r_addr <= (r_addr << 8) | ADDR_W'(bus.rx_data);
            if ((r_state == S_DATA) && bus.rx_valid)
                r_wdata <= (r_wdata << 8) | DATA_W'(bus.rx_data);

`ifdef UART_FLASH_BRIDGE_CHECKSUM_EN
            if ((r_state == S_IDLE) && bus.rx_valid)
                r_csum <= bus.rx_data;
            else if (((r_state == S_ADDR) || (r_state == S_DATA)) && bus.rx_valid)
                r_csum <= r_csum ^ bus.rx_data;
`endif

            if (w_nak)
                r_nak <= 1'b1;
            else if (r_state == S_IDLE)
                r_nak <= 1'b0;

            case (r_state)
                S_FL_WAIT: begin
                    if (bus.fl_done) r_resp <= bus.fl_rdata;
                end
                S_RESP: begin
                    if (r_nak || !r_op_rd) begin
                        r_resp    <= DATA_W'(r_nak ? c_NAK : c_ACK) << (DATA_W - 8);
                        r_tx_left <= 2'd1;
                    end else begin
                        r_tx_left <= 2'(c_DATA_BYTES);
                    end
                end
                S_TX_WAIT: begin
                    if (w_tx_fire) begin
                        r_resp    <= r_resp << 8;
                        r_tx_left <= r_tx_left - 2'd1;
                    end
                end
                default: ;
            endcase

            r_tx_skip <= w_tx_fire;

            if (w_err && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign bus.tx_data  = r_resp[DATA_W-1 -: 8];
    assign bus.tx_start = w_tx_fire;
    assign bus.fl_addr  = r_addr;
    assign bus.fl_wdata = r_wdata;
    assign bus.fl_rw    = r_op_rd;
    assign bus.fl_start = (r_state == S_FL_REQ);
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_flash_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_flash_bridge
//  Description : Self-checking bench for uart_flash_bridge. Two instances:
//                dut0 (ADDR_W=16, DATA_W=8) and dut1 (ADDR_W=24, DATA_W=16),
//                both with short timeouts. Expected flash requests and TX
//                bytes are queued when commands are sent and compared when
//                the DUT emits FL_START / TX_START.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_flash_bridge;

    localparam int c_RXTO = 40;
    localparam int c_FLTO = 30;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_flash_bridge_if #(.ADDR_W(16), .DATA_W(8))  bus0 ();
    uart_flash_bridge_if #(.ADDR_W(24), .DATA_W(16)) bus1 ();

    uart_flash_bridge #(.ADDR_W(16), .DATA_W(8), .RX_TIMEOUT(c_RXTO), .FL_TIMEOUT(c_FLTO))
        dut0 (.CLK_50MHZ(clk), .RST_N(rst_n), .bus(bus0));
    uart_flash_bridge #(.ADDR_W(24), .DATA_W(16), .RX_TIMEOUT(c_RXTO), .FL_TIMEOUT(c_FLTO))
        dut1 (.CLK_50MHZ(clk), .RST_N(rst_n), .bus(bus1));

    int n_chk  = 0;
    int n_pass = 0;
    int exp_err0 = 0;

    // {rw, addr[23:0], wdata[15:0]} packed into the low 41 bits
    logic [63:0] q_fl0[$];
    logic [63:0] q_fl1[$];
    logic [7:0]  q_tx0[$];
    logic [7:0]  q_tx1[$];

    int          fl_mode0 = 0;      // 0: answer FL_START, 1: never answer
    logic [7:0]  fl_rd0   = 8'h00;
    logic [15:0] fl_rd1   = 16'h0000;
    logic        lat_chk0 = 1'b0;
    logic [7:0]  cmd[8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] fl_pack(input logic rw, input logic [23:0] a, input logic [15:0] d);
        return {23'b0, rw, a, d};
    endfunction

    // ---------------- monitors ----------------
    initial forever begin
        @(negedge clk);
        if (bus0.fl_start) begin
            if (q_fl0.size() == 0) begin
                check("fl0_unexpected_start", 64'(bus0.fl_start), 64'(0));
            end else begin
                logic [63:0] e;
                logic [63:0] o;
                e = q_fl0.pop_front();
                o = fl_pack(bus0.fl_rw, 24'(bus0.fl_addr), 16'(bus0.fl_wdata));
                check("fl0_rw_addr", o[40:16], e[40:16]);
                if (!e[40]) check("fl0_wdata", o[15:0], e[15:0]);
            end
        end
        if (bus0.tx_start) begin
            check("tx0_busy_at_start", 64'(bus0.tx_busy), 64'(0));
            if (q_tx0.size() == 0) check("tx0_unexpected_start", 64'(bus0.tx_start), 64'(0));
            else                   check("tx0_data", 64'(bus0.tx_data), 64'(q_tx0.pop_front()));
        end
    end

    initial forever begin
        @(negedge clk);
        if (bus1.fl_start) begin
            if (q_fl1.size() == 0) begin
                check("fl1_unexpected_start", 64'(bus1.fl_start), 64'(0));
            end else begin
                logic [63:0] e;
                logic [63:0] o;
                e = q_fl1.pop_front();
                o = fl_pack(bus1.fl_rw, bus1.fl_addr, bus1.fl_wdata);
                check("fl1_rw_addr", o[40:16], e[40:16]);
                if (!e[40]) check("fl1_wdata", o[15:0], e[15:0]);
            end
        end
        if (bus1.tx_start) begin
            check("tx1_busy_at_start", 64'(bus1.tx_busy), 64'(0));
            if (q_tx1.size() == 0) check("tx1_unexpected_start", 64'(bus1.tx_start), 64'(0));
            else                   check("tx1_data", 64'(bus1.tx_data), 64'(q_tx1.pop_front()));
        end
    end

    // ---------------- UART transmitter models (1-cycle latency, 8 busy) ----------------
    initial forever begin
        @(negedge clk);
        if (bus0.tx_start) begin
            @(posedge clk); #1 bus0.tx_busy = 1'b1;
            repeat (8) @(posedge clk);
            #1 bus0.tx_busy = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (bus1.tx_start) begin
            @(posedge clk); #1 bus1.tx_busy = 1'b1;
            repeat (8) @(posedge clk);
            #1 bus1.tx_busy = 1'b0;
        end
    end

    // ---------------- flash controller models ----------------
    initial forever begin
        @(negedge clk);
        if (bus0.fl_start && (fl_mode0 == 0)) begin
            repeat (2) @(posedge clk);
            #1 bus0.fl_rdata = fl_rd0; bus0.fl_done = 1'b1;
            @(posedge clk); #1 bus0.fl_done = 1'b0;
            if (lat_chk0) begin
                @(posedge clk); #1;
                check("tx_start_2_after_done", 64'(bus0.tx_start), 64'(1));
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (bus1.fl_start) begin
            repeat (2) @(posedge clk);
            #1 bus1.fl_rdata = fl_rd1; bus1.fl_done = 1'b1;
            @(posedge clk); #1 bus1.fl_done = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input int d, input logic [7:0] b);
        @(negedge clk);
        if (d == 0) begin bus0.rx_data = b; bus0.rx_valid = 1'b1; end
        else        begin bus1.rx_data = b; bus1.rx_valid = 1'b1; end
        @(negedge clk);
        bus0.rx_valid = 1'b0;
        bus1.rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input int d, input int n);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            send_byte(d, cmd[i]);
            x = x ^ cmd[i];
        end
`ifdef UART_FLASH_BRIDGE_CHECKSUM_EN
        send_byte(d, x);
`endif
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (((q_tx0.size() != 0) || (q_tx1.size() != 0) || bus0.busy || bus1.busy) && (n < 400)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check(tag, 64'(n), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bus0.rx_data = '0; bus0.rx_valid = 1'b0; bus0.tx_busy = 1'b0;
        bus0.fl_rdata = '0; bus0.fl_done = 1'b0;
        bus1.rx_data = '0; bus1.rx_valid = 1'b0; bus1.tx_busy = 1'b0;
        bus1.fl_rdata = '0; bus1.fl_done = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_busy",     64'(bus0.busy),     64'(0));
        check("rst_err_cnt",  64'(bus0.err_cnt),  64'(0));
        check("rst_fl_start", 64'(bus0.fl_start), 64'(0));
        check("rst_tx_start", 64'(bus0.tx_start), 64'(0));
        check("rst_tx_data",  64'(bus0.tx_data),  64'(0));
        check("rst_fl_addr",  64'(bus0.fl_addr),  64'(0));
        check("rst_fl_rw",    64'(bus0.fl_rw),    64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write 0x1234 <- 0xA5, expect ACK
        cmd[0] = 8'h57; cmd[1] = 8'h12; cmd[2] = 8'h34; cmd[3] = 8'hA5;
        q_fl0.push_back(fl_pack(1'b0, 24'h001234, 16'h00A5));
        q_tx0.push_back(8'h06);
        lat_chk0 = 1'b1;
        send_cmd(0, 4);
        check("fl_start_1_after_last_rx", 64'(bus0.fl_start), 64'(1));
        wait_idle("t1_idle_timeout");
        lat_chk0 = 1'b0;
        check("t1_busy_low", 64'(bus0.busy), 64'(0));

        // Read 0x0010 -> 0x3C
        fl_rd0 = 8'h3C;
        cmd[0] = 8'h52; cmd[1] = 8'h00; cmd[2] = 8'h10;
        q_fl0.push_back(fl_pack(1'b1, 24'h000010, 16'h0000));
        q_tx0.push_back(8'h3C);
        send_cmd(0, 3);
        wait_idle("t2_idle_timeout");

        // Wide instance: read 0x010203 -> 0xBEEF, two reply bytes
        fl_rd1 = 16'hBEEF;
        cmd[0] = 8'h52; cmd[1] = 8'h01; cmd[2] = 8'h02; cmd[3] = 8'h03;
        q_fl1.push_back(fl_pack(1'b1, 24'h010203, 16'h0000));
        q_tx1.push_back(8'hBE);
        q_tx1.push_back(8'hEF);
        send_cmd(1, 4);
        wait_idle("t3_idle_timeout");

        // Unknown opcode
        q_tx0.push_back(8'h15);
        send_byte(0, 8'h41);
        exp_err0++;
        wait_idle("t4_idle_timeout");
        check("bad_opcode_err_cnt", 64'(bus0.err_cnt), 64'(exp_err0));

        // Inter-byte timeout
        q_tx0.push_back(8'h15);
        send_byte(0, 8'h57);
        send_byte(0, 8'h12);
        repeat (c_RXTO - 6) @(negedge clk);
        check("rx_timeout_not_early", 64'(q_tx0.size()), 64'(1));
        exp_err0++;
        wait_idle("t5_idle_timeout");
        check("rx_timeout_err_cnt", 64'(bus0.err_cnt), 64'(exp_err0));

        // Flash never answers; stray byte while waiting
        fl_mode0 = 1;
        cmd[0] = 8'h57; cmd[1] = 8'hAB; cmd[2] = 8'hCD; cmd[3] = 8'hEF;
        q_fl0.push_back(fl_pack(1'b0, 24'h00ABCD, 16'h00EF));
        q_tx0.push_back(8'h15);
        send_cmd(0, 4);
        repeat (4) @(negedge clk);
        send_byte(0, 8'h99);
        exp_err0++;
        check("drop_in_fl_wait_err_cnt", 64'(bus0.err_cnt), 64'(exp_err0));
        check("drop_in_fl_wait_busy", 64'(bus0.busy), 64'(1));
        exp_err0++;
        wait_idle("t6_idle_timeout");
        check("fl_timeout_err_cnt", 64'(bus0.err_cnt), 64'(exp_err0));
        fl_mode0 = 0;

`ifdef UART_FLASH_BRIDGE_CHECKSUM_EN
        // Explicit checksum bytes: 0xD4 is good, 0x00 is bad
        q_fl0.push_back(fl_pack(1'b0, 24'h001234, 16'h00A5));
        q_tx0.push_back(8'h06);
        send_byte(0, 8'h57); send_byte(0, 8'h12); send_byte(0, 8'h34);
        send_byte(0, 8'hA5); send_byte(0, 8'hD4);
        wait_idle("t7_idle_timeout");
        q_tx0.push_back(8'h15);
        send_byte(0, 8'h57); send_byte(0, 8'h12); send_byte(0, 8'h34);
        send_byte(0, 8'hA5); send_byte(0, 8'h00);
        exp_err0++;
        wait_idle("t8_idle_timeout");
        check("csum_bad_err_cnt", 64'(bus0.err_cnt), 64'(exp_err0));
`endif

        // Asynchronous reset while waiting on flash; late FL_DONE ignored
        fl_mode0 = 1;
        cmd[0] = 8'h57; cmd[1] = 8'h55; cmd[2] = 8'h66; cmd[3] = 8'h77;
        q_fl0.push_back(fl_pack(1'b0, 24'h005566, 16'h0077));
        send_cmd(0, 4);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_err0 = 0;
        check("async_rst_busy",    64'(bus0.busy),    64'(0));
        check("async_rst_err_cnt", 64'(bus0.err_cnt), 64'(0));
        check("async_rst_fl_addr", 64'(bus0.fl_addr), 64'(0));
        check("async_rst_fl_rw",   64'(bus0.fl_rw),   64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        bus0.fl_done = 1'b1;
        @(negedge clk);
        bus0.fl_done = 1'b0;
        repeat (20) @(negedge clk);
        check("late_done_busy",    64'(bus0.busy),    64'(0));
        check("late_done_err_cnt", 64'(bus0.err_cnt), 64'(0));
        fl_mode0 = 0;

        // Saturation: 256 unknown opcodes from zero
        for (int i = 0; i < 256; i++) begin
            q_tx0.push_back(8'h15);
            send_byte(0, 8'h41);
            if (exp_err0 < 255) exp_err0++;
            wait_idle("sat_idle_timeout");
            if (i == 254) check("err_cnt_reaches_255", 64'(bus0.err_cnt), 64'(exp_err0));
        end
        check("err_cnt_saturated", 64'(bus0.err_cnt), 64'(exp_err0));

        repeat (5) @(negedge clk);
        check("fl0_left", 64'(q_fl0.size()), 64'(0));
        check("fl1_left", 64'(q_fl1.size()), 64'(0));
        check("tx0_left", 64'(q_tx0.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_flash_bridge.md
Name: uart_flash_bridge

Overview:
- Parametrised command bridge between the UART byte interface and the Flash controller handshake.
- Replaces the fixed 8-bit-address manager with configurable address and data widths, timeouts, error counting and response codes.
- Sits in the top level between UART (RX/TX byte strobes) and Flash (start/done/direction).
- Host protocol:
  - 'W' (0x57), then address bytes, then data bytes → flash write, reply ACK (0x06).
  - 'R' (0x52), then address bytes → flash read, reply with the data bytes.

Parameters:
- ADDR_W, 16, flash address width; multiple of 8, range 8..24; ADDR_BYTES = ADDR_W/8.
- DATA_W, 8, flash data width; 8 or 16; DATA_BYTES = DATA_W/8.
- RX_TIMEOUT, 5_000_000, max idle cycles between bytes of one command (100 ms at 50 MHz).
- FL_TIMEOUT, 50_000, max cycles waiting for FL_DONE.

Ports:
- CLK_50MHZ  in  1  system clock
- RST_N  in  1  asynchronous, active-low reset
- RX_DATA  in  8  received byte
- RX_VALID  in  1  one-cycle strobe, RX_DATA valid
- TX_DATA  out  8  byte to transmit
- TX_START  out  1  one-cycle strobe to UART transmitter
- TX_BUSY  in  1  UART transmitter busy
- FL_ADDR  out  ADDR_W  flash address
- FL_WDATA  out  DATA_W  flash write data
- FL_RDATA  in  DATA_W  flash read data, valid when FL_DONE=1
- FL_RW  out  1  1=read, 0=write
- FL_START  out  1  one-cycle strobe to flash controller
- FL_DONE  in  1  one-cycle completion strobe
- BUSY  out  1  high in every state except IDLE
- ERR_CNT  out  8  saturating error counter

Behaviour:
- Reset (RST_N low, async): state IDLE; all outputs 0; shift registers and counters 0.
- Multi-byte fields are MSB byte first.
- States and transitions:
  - IDLE:
    - RX_VALID with 0x57 → ADDR, op=write.
    - RX_VALID with 0x52 → ADDR, op=read.
    - Any other byte → RESP with NAK (0x15), ERR_CNT+1.
  - ADDR: shift in ADDR_BYTES bytes. After the last byte: write → DATA; read → FL_REQ (or CSUM when the option is enabled).
  - DATA: shift in DATA_BYTES bytes, then → FL_REQ (or CSUM when enabled).
  - FL_REQ: FL_START=1 for exactly one cycle; FL_ADDR, FL_WDATA and FL_RW are stable from this cycle until FL_DONE → FL_WAIT.
  - FL_WAIT:
    - FL_DONE → RESP. Read: capture FL_RDATA in the same cycle. Write: response is ACK.
    - FL_TIMEOUT cycles without FL_DONE → RESP with NAK, ERR_CNT+1.
  - RESP: load the response (1 byte, or DATA_BYTES bytes for a read) → TX_WAIT.
  - TX_WAIT:
    - Wait for TX_BUSY=0, then pulse TX_START for one cycle with TX_DATA held.
    - Ignore TX_BUSY in the cycle after TX_START (UART latency), then wait for TX_BUSY=0 again.
    - Repeat for the remaining bytes; after the last byte → IDLE.
- Inter-byte timeout: in ADDR/DATA/CSUM, the counter resets on each RX_VALID. Reaching RX_TIMEOUT → RESP with NAK, ERR_CNT+1; partial command discarded.
- RX_VALID in FL_REQ/FL_WAIT/RESP/TX_WAIT: byte dropped, ERR_CNT+1; state unchanged.
- ERR_CNT saturates at 255 and never wraps. If two error events coincide, it increments once.
- Latency (write command, idle flash and UART): FL_START asserts 1 cycle after the RX_VALID of the last command byte. The first TX_START follows 2 cycles after FL_DONE.
- FL_DONE outside FL_WAIT: ignored.
- Reset mid-operation: immediate return to IDLE. An in-flight flash operation is not cancelled; its later FL_DONE is ignored.

Optional Feature:
- Macro: UART_FLASH_BRIDGE_CHECKSUM_EN.
- Enabled:
  - Every command carries one extra byte (state CSUM) after the last address/data byte.
  - Expected value: XOR of the opcode and all following bytes equals the checksum.
  - Match → FL_REQ.
  - Mismatch → RESP with NAK (0x15), ERR_CNT+1, no FL_START issued.
- Disabled: CSUM state absent; the command ends at its last address/data byte.

Test Plan:
- Defaults (ADDR_W=16, DATA_W=8), RX 0x57 0x12 0x34 0xA5 → one FL_START with FL_ADDR=0x1234, FL_WDATA=0xA5, FL_RW=0; after FL_DONE, TX 0x06; BUSY returns 0.
- RX 0x52 0x00 0x10; flash returns FL_RDATA=0x3C with FL_DONE → FL_RW=1, FL_ADDR=0x0010; TX 0x3C.
- DATA_W=16, ADDR_W=24: RX 0x52 0x01 0x02 0x03, FL_RDATA=0xBEEF → FL_ADDR=0x010203; TX 0xBE then 0xEF; second TX_START only after TX_BUSY deasserts.
- RX 0x41 → TX 0x15, ERR_CNT=1, no FL_START. RX 0x57 0x12 then silence of RX_TIMEOUT cycles → TX 0x15, ERR_CNT=2.
- Write command with FL_DONE never asserted → NAK after FL_TIMEOUT cycles. Then 256 further unknown opcodes → ERR_CNT=255 (saturated).
- CHECKSUM_EN: RX 0x57 0x12 0x34 0xA5 0xD4 → write, ACK; same with checksum 0x00 → NAK, no FL_START. Also: assert RST_N=0 during FL_WAIT → outputs 0 immediately; later FL_DONE ignored.
